// File: rtl/controle_senhas.sv
// controle_senhas: bomb-defusal password FSM with two phases and limited attempts.
// Define PENALIDADE_EN to pulse PENALIDADE on each wrong attempt.
module controle_senhas #(
  parameter int MAX_TENTATIVAS = 5
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       START,
  input  logic       ENTER,
  input  logic [3:0] TENTATIVA,
  input  logic [3:0] SENHA_A,
  input  logic [2:0] SENHA_B,
  input  logic       TIMEOUT,
  output logic [2:0] ESTADO,
  output logic       DICA_ENABLE,
  output logic       ACERTOU_SENHA_A,
  output logic       DICA_STROBE,
  output logic [2:0] TENTATIVAS_RESTANTES,
  output logic       DESARMADA,
  output logic       EXPLODIU,
  output logic       PENALIDADE
);
  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    FASE_A    = 3'd1,
    FASE_B    = 3'd2,
    ST_DESARM = 3'd3,
    ST_EXPLOD = 3'd4
  } state_t;
  localparam logic [2:0] MAX = 3'(MAX_TENTATIVAS);
  state_t state, next;
  logic s1, s2, prev, armed, evt;
  logic [1:0] warm;
  logic [2:0] cnt_n;
  logic strobe_n, acertou_n;
  // armed stays low until ENTER is seen released after reset, so a held button never fires
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
      warm <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1 <= ENTER;
      s2 <= s1;
      prev <= s2;
      warm <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & ~s2);
    end
  assign evt = s2 & ~prev & armed;
  always_comb begin
    next = state;
    cnt_n = TENTATIVAS_RESTANTES;
    strobe_n = 1'b0;
    acertou_n = ACERTOU_SENHA_A;
    case (state)
      OCIOSO: if (START) begin
        next = FASE_A;
        cnt_n = MAX;
      end
      FASE_A, FASE_B: if (TIMEOUT) next = ST_EXPLOD;
      else if (evt) begin
        if (state == FASE_A && TENTATIVA == SENHA_A) begin
          next = FASE_B;
          cnt_n = MAX;
          acertou_n = 1'b1;
        end else if (state == FASE_B && TENTATIVA == {1'b0, SENHA_B}) next = ST_DESARM;
        else begin
          cnt_n = TENTATIVAS_RESTANTES - 3'd1;
          strobe_n = 1'b1;
          next = TENTATIVAS_RESTANTES <= 3'd1 ? ST_EXPLOD : state;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) begin
      state <= OCIOSO;
      TENTATIVAS_RESTANTES <= 3'd0;
      DICA_STROBE <= 1'b0;
      ACERTOU_SENHA_A <= 1'b0;
      DICA_ENABLE <= 1'b0;
      DESARMADA <= 1'b0;
      EXPLODIU <= 1'b0;
    end else begin
      state <= next;
      TENTATIVAS_RESTANTES <= cnt_n;
      DICA_STROBE <= strobe_n;
      ACERTOU_SENHA_A <= acertou_n;
      DICA_ENABLE <= next == FASE_A || next == FASE_B;
      DESARMADA <= next == ST_DESARM;
      EXPLODIU <= next == ST_EXPLOD;
    end
  assign ESTADO = state;
`ifdef PENALIDADE_EN
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) PENALIDADE <= 1'b0;
    else PENALIDADE <= strobe_n;
`else
  assign PENALIDADE = 1'b0;
`endif
endmodule

// File: tb/tb_controle_senhas.sv
// tb_controle_senhas: directed scoreboard bench for controle_senhas.
module tb_controle_senhas;
`ifdef PENALIDADE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic CLOCK_50 = 0, RESET = 0, START = 0, ENTER = 0, TIMEOUT = 0;
  logic [3:0] TENTATIVA = 0, SENHA_A = 0;
  logic [2:0] SENHA_B = 0;
  logic [2:0] ESTADO, TENTATIVAS_RESTANTES;
  logic DICA_ENABLE, ACERTOU_SENHA_A, DICA_STROBE, DESARMADA, EXPLODIU, PENALIDADE;
  logic [11:0] obs;
  logic [11:0] sb[$];
  int cmp = 0, mism = 0;
  controle_senhas dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .START(START), .ENTER(ENTER),
    .TENTATIVA(TENTATIVA), .SENHA_A(SENHA_A), .SENHA_B(SENHA_B), .TIMEOUT(TIMEOUT),
    .ESTADO(ESTADO), .DICA_ENABLE(DICA_ENABLE), .ACERTOU_SENHA_A(ACERTOU_SENHA_A),
    .DICA_STROBE(DICA_STROBE), .TENTATIVAS_RESTANTES(TENTATIVAS_RESTANTES),
    .DESARMADA(DESARMADA), .EXPLODIU(EXPLODIU), .PENALIDADE(PENALIDADE)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  assign obs = {ESTADO, TENTATIVAS_RESTANTES, DICA_STROBE, ACERTOU_SENHA_A,
                DESARMADA, EXPLODIU, PENALIDADE, DICA_ENABLE};
  function automatic logic [11:0] mk(input int st, input int c, input bit stb, input bit ac);
    logic [2:0] s;
    s = 3'(st);
    return {s, 3'(c), stb, ac, s == 3'd3, s == 3'd4, stb & PEN, s == 3'd1 || s == 3'd2};
  endfunction
  task automatic chk(input string tag);
    logic [11:0] e;
    e = sb.pop_front();
    cmp++;
    assert (obs === e) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask
  task automatic chk_val(input string tag, input int o, input int e);
    cmp++;
    assert (o === e) else begin
      mism++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  task automatic do_reset();
    @(negedge CLOCK_50);
    RESET = 1; START = 0; ENTER = 0; TIMEOUT = 0;
    sb.push_back(mk(0, 0, 0, 0));
    #1 chk("reset");
    @(negedge CLOCK_50) RESET = 0;
    repeat (5) @(negedge CLOCK_50);
  endtask
  task automatic arm(input string tag);
    @(negedge CLOCK_50) START = 1;
    sb.push_back(mk(1, 5, 0, 0));
    @(posedge CLOCK_50) #1 chk(tag);
    @(negedge CLOCK_50) START = 0;
  endtask
  // result lands on the third edge after ENTER rises; the strobe must then drop
  task automatic press(input string tag, input logic [3:0] v, input int st, input int c,
                       input bit stb, input bit ac);
    @(negedge CLOCK_50);
    TENTATIVA = v; ENTER = 1;
    sb.push_back(mk(st, c, stb, ac));
    sb.push_back(mk(st, c, 0, ac));
    repeat (3) @(posedge CLOCK_50);
    #1 chk(tag);
    @(posedge CLOCK_50) #1 chk({tag, "_next"});
    @(negedge CLOCK_50) ENTER = 0;
    repeat (5) @(negedge CLOCK_50);
  endtask
  initial begin
    int nstb, npen;
    do_reset();
    press("idle_evt", 4'hA, 0, 0, 0, 0);
    SENHA_A = 4'hA; SENHA_B = 3'b101;
    arm("start");
    press("a_ok", 4'hA, 2, 5, 0, 1);
    press("b_bit3", 4'b1101, 2, 4, 1, 1);
    press("b_ok", 4'b0101, 3, 4, 0, 1);
    START = 1; TIMEOUT = 1;
    press("desarm_term", 4'b0011, 3, 4, 0, 1);
    do_reset();
    arm("start2");
    for (int i = 4; i >= 1; i--) press("a_wrong", 4'h3, 1, i, 1, 0);
    press("a_boom", 4'h3, 4, 0, 1, 0);
    TIMEOUT = 1; START = 1;
    press("explod_term", 4'hA, 4, 0, 0, 0);
    do_reset();
    arm("start3");
    press("a_wrong1", 4'h3, 1, 4, 1, 0);
    @(negedge CLOCK_50);
    TENTATIVA = 4'h3; ENTER = 1;
    sb.push_back(mk(4, 4, 0, 0));
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50) TIMEOUT = 1;
    @(posedge CLOCK_50) #1 chk("timeout_wins");
    do_reset();
    arm("start4");
    @(negedge CLOCK_50);
    TENTATIVA = 4'h3; ENTER = 1; nstb = 0; npen = 0;
    sb.push_back(mk(1, 4, 0, 0));
    repeat (100) begin
      @(posedge CLOCK_50) #1;
      nstb += int'(DICA_STROBE);
      npen += int'(PENALIDADE);
    end
    chk("held_state");
    chk_val("held_strobes", nstb, 1);
    chk_val("held_penalties", npen, int'(PEN));
    @(negedge CLOCK_50) ENTER = 0;
    do_reset();
    arm("start5");
    @(negedge CLOCK_50);
    TENTATIVA = 4'h3; ENTER = 1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50) RESET = 1;
    sb.push_back(mk(0, 0, 0, 0));
    #1 chk("rst_mid");
    @(negedge CLOCK_50) RESET = 0;
    sb.push_back(mk(0, 0, 0, 0));
    repeat (10) @(negedge CLOCK_50);
    chk("rst_inflight");
    arm("start6");
    sb.push_back(mk(1, 5, 0, 0));
    repeat (10) @(posedge CLOCK_50);
    #1 chk("held_after_rst");
    @(negedge CLOCK_50) ENTER = 0;
    repeat (5) @(negedge CLOCK_50);
    press("after_release", 4'h3, 1, 4, 1, 0);
    chk_val("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
